// File: rtl/id_branch_predictor.sv
// Direct-mapped dynamic branch predictor: tagged saturating counters with
// stored targets, combinational lookup for IF and registered training from ID.
module id_branch_predictor #(
  parameter int PC_SIZE      = 32,
  parameter int BHT_DEPTH    = 64,
  parameter int TAG_SIZE     = 8,
  parameter int COUNTER_BITS = 2,
  parameter int STAT_SIZE    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_lookup_valid,
  input  logic [PC_SIZE-1:0]   i_lookup_pc,
  output logic                 o_pred_hit,
  output logic                 o_pred_taken,
  output logic [PC_SIZE-1:0]   o_pred_target,
  input  logic                 i_update_valid,
  input  logic [PC_SIZE-1:0]   i_update_pc,
  input  logic                 i_update_taken,
  input  logic [PC_SIZE-1:0]   i_update_target,
  input  logic                 i_update_pred_taken,
  input  logic                 i_flush,
  output logic [STAT_SIZE-1:0] o_lookup_count,
  output logic [STAT_SIZE-1:0] o_mispredict_count
);

  localparam int IW = $clog2(BHT_DEPTH);
  localparam logic [COUNTER_BITS-1:0] C_WT =
    COUNTER_BITS'(1 << (COUNTER_BITS - 1));
  localparam logic [COUNTER_BITS-1:0] C_WNT =
    COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
  localparam logic [COUNTER_BITS-1:0] C_MAX = '1;

  logic                    r_valid [BHT_DEPTH];
  logic [TAG_SIZE-1:0]     r_tag   [BHT_DEPTH];
  logic [COUNTER_BITS-1:0] r_cnt   [BHT_DEPTH];
  logic [PC_SIZE-1:0]      r_tgt   [BHT_DEPTH];
  logic [STAT_SIZE-1:0]    r_lcnt;
  logic [STAT_SIZE-1:0]    r_mcnt;

  logic [IW-1:0]       w_l_idx;
  logic [TAG_SIZE-1:0] w_l_tag;
  logic [IW-1:0]       w_u_idx;
  logic [TAG_SIZE-1:0] w_u_tag;
  logic                w_l_hit;
  logic                w_u_hit;
  logic                w_mis;
  logic                w_unused;

  assign w_l_idx = i_lookup_pc[IW+1:2];
  assign w_l_tag = i_lookup_pc[IW+2 +: TAG_SIZE];
  assign w_u_idx = i_update_pc[IW+1:2];
  assign w_u_tag = i_update_pc[IW+2 +: TAG_SIZE];
  assign w_unused = ^{i_update_pc, i_lookup_pc};

  // Reset also masks the hit so no stale entry is reported in that cycle.
  assign w_l_hit = i_lookup_valid & ~i_reset & r_valid[w_l_idx] &
                   (r_tag[w_l_idx] == w_l_tag);
  assign w_u_hit = r_valid[w_u_idx] & (r_tag[w_u_idx] == w_u_tag);

  assign w_mis = (i_update_pred_taken != i_update_taken) |
                 (i_update_taken & i_update_pred_taken &
                  (r_tgt[w_u_idx] != i_update_target));

  always_comb begin
    o_pred_hit    = w_l_hit;
    o_pred_taken  = w_l_hit & r_cnt[w_l_idx][COUNTER_BITS-1];
    o_pred_target = '0;
    if (o_pred_taken)
      o_pred_target = r_tgt[w_l_idx];
    else if (i_lookup_valid)
      o_pred_target = i_lookup_pc + PC_SIZE'(4);
  end

  assign o_lookup_count     = r_lcnt;
  assign o_mispredict_count = r_mcnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_cnt[i]   <= C_WNT;
        r_tgt[i]   <= '0;
      end
      r_lcnt <= '0;
      r_mcnt <= '0;
    end else begin
      if (i_lookup_valid && r_lcnt != '1)
        r_lcnt <= r_lcnt + 1'b1;
      // A flushed update still reports its mispredict.
      if (i_update_valid && w_mis && r_mcnt != '1)
        r_mcnt <= r_mcnt + 1'b1;
      if (i_flush) begin
        for (int i = 0; i < BHT_DEPTH; i++)
          r_valid[i] <= 1'b0;
      end else if (i_update_valid) begin
        if (w_u_hit) begin
          if (i_update_taken) begin
            if (r_cnt[w_u_idx] != C_MAX)
              r_cnt[w_u_idx] <= r_cnt[w_u_idx] + 1'b1;
            r_tgt[w_u_idx] <= i_update_target;
          end else if (r_cnt[w_u_idx] != '0) begin
            r_cnt[w_u_idx] <= r_cnt[w_u_idx] - 1'b1;
          end
        end else if (i_update_taken) begin
          r_valid[w_u_idx] <= 1'b1;
          r_tag[w_u_idx]   <= w_u_tag;
          r_cnt[w_u_idx]   <= C_WT;
          r_tgt[w_u_idx]   <= i_update_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_branch_predictor.sv
// Randomized and directed bench for id_branch_predictor against an
// array-based reference model; a second DUT checks 4-bit stat saturation.
module tb_id_branch_predictor;

  localparam int DEPTH = 64;
  localparam int CMAX  = 3;
  localparam int CWT   = 2;
  localparam int CWNT  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        lv;
  logic [31:0] lpc;
  logic        uv;
  logic [31:0] upc;
  logic        ut;
  logic [31:0] utgt;
  logic        upt;
  logic        fl;

  logic        hit, tkn;
  logic [31:0] tgt, lcnt, mcnt;
  logic        hit4, tkn4;
  logic [31:0] tgt4;
  logic [3:0]  lcnt4, mcnt4;

  int checks = 0;
  int errors = 0;

  bit          m_v   [DEPTH];
  int          m_tag [DEPTH];
  int          m_cnt [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  longint      m_l;
  longint      m_m;

  logic        o_hit, o_tkn;
  logic [31:0] o_tgt;

  always #5 clk = ~clk;

  id_branch_predictor dut (
    .i_clk(clk), .i_reset(rst),
    .i_lookup_valid(lv), .i_lookup_pc(lpc),
    .o_pred_hit(hit), .o_pred_taken(tkn), .o_pred_target(tgt),
    .i_update_valid(uv), .i_update_pc(upc), .i_update_taken(ut),
    .i_update_target(utgt), .i_update_pred_taken(upt),
    .i_flush(fl),
    .o_lookup_count(lcnt), .o_mispredict_count(mcnt)
  );

  id_branch_predictor #(.STAT_SIZE(4)) dut4 (
    .i_clk(clk), .i_reset(rst),
    .i_lookup_valid(lv), .i_lookup_pc(lpc),
    .o_pred_hit(hit4), .o_pred_taken(tkn4), .o_pred_target(tgt4),
    .i_update_valid(uv), .i_update_pc(upc), .i_update_taken(ut),
    .i_update_target(utgt), .i_update_pred_taken(upt),
    .i_flush(fl),
    .o_lookup_count(lcnt4), .o_mispredict_count(mcnt4)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[31:2]) % DEPTH;
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'(pc >> 8) % 256;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_cnt[i] = CWNT; m_tgt[i] = 0;
    end
    m_l = 0;
    m_m = 0;
  endtask

  task automatic cycle(input bit r, input bit l_v, input logic [31:0] l_pc,
                       input bit u_v, input logic [31:0] u_pc, input bit u_t,
                       input logic [31:0] u_tgt, input bit u_pt,
                       input bit f);
    int  li, ui;
    bit  ehit, etkn, uhit, mis;
    logic [31:0] etgt;
    rst = r; lv = l_v; lpc = l_pc; uv = u_v; upc = u_pc;
    ut = u_t; utgt = u_tgt; upt = u_pt; fl = f;
    #3;
    li   = idx_of(l_pc);
    ehit = l_v && !r && m_v[li] && m_tag[li] == tag_of(l_pc);
    etkn = ehit && m_cnt[li] >= CWT;
    etgt = etkn ? m_tgt[li] : (l_v ? l_pc + 32'd4 : 32'd0);
    o_hit = hit; o_tkn = tkn; o_tgt = tgt;
    chk("hit", hit, ehit);
    chk("taken", tkn, etkn);
    chk("target", tgt, etgt);
    chk("hit4", hit4, ehit);
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      ui   = idx_of(u_pc);
      uhit = m_v[ui] && m_tag[ui] == tag_of(u_pc);
      mis  = (u_pt != u_t) || (u_t && u_pt && m_tgt[ui] != u_tgt);
      if (l_v) m_l++;
      if (u_v && mis) m_m++;
      if (f) begin
        for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
      end else if (u_v) begin
        if (uhit && u_t) begin
          m_cnt[ui] = (m_cnt[ui] < CMAX) ? m_cnt[ui] + 1 : CMAX;
          m_tgt[ui] = u_tgt;
        end else if (uhit) begin
          m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
        end else if (u_t) begin
          m_v[ui] = 1; m_tag[ui] = tag_of(u_pc);
          m_cnt[ui] = CWT; m_tgt[ui] = u_tgt;
        end
      end
    end
    chk("lookup_count", lcnt, sat(m_l, 32'hFFFF_FFFF));
    chk("mispredict_count", mcnt, sat(m_m, 32'hFFFF_FFFF));
    chk("lookup_count4", lcnt4, sat(m_l, 15));
    chk("mispredict_count4", mcnt4, sat(m_m, 15));
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(0, 1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t,
                     input logic [31:0] target, input bit pt);
    cycle(0, 0, 0, 1, pc, t, target, pt, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    model_reset();
    cycle(1, 0, 0, 1, 32'h40, 1, 32'h999, 0, 0);
    cycle(1, 1, 32'h40, 1, 32'h40, 1, 32'h999, 0, 0);
    chk("rst_target", o_tgt, 32'h44);

    look(32'h40);
    chk("tp1_hit", o_hit, 0);
    chk("tp1_target", o_tgt, 32'h44);
    chk("tp1_lcount", lcnt, 1);

    upd(32'h40, 1, 32'h100, 0);
    chk("tp2_mcount", mcnt, 1);
    look(32'h40);
    chk("tp2_hit", o_hit, 1);
    chk("tp2_target", o_tgt, 32'h100);

    upd(32'h40, 0, 0, 1);
    upd(32'h40, 0, 0, 1);
    look(32'h40);
    chk("tp3_taken", o_tkn, 0);
    chk("tp3_target", o_tgt, 32'h44);
    upd(32'h40, 0, 0, 0);
    upd(32'h40, 1, 32'h200, 1);
    look(32'h40);
    chk("tp3_floor_taken", o_tkn, 0);

    upd(32'h40, 1, 32'h200, 0);
    look(32'h40 + 4 * DEPTH);
    chk("alias_miss", o_hit, 0);
    upd(32'h40 + 4 * DEPTH, 1, 32'h300, 0);
    look(32'h40);
    chk("alias_evict", o_hit, 0);
    look(32'h40 + 4 * DEPTH);
    chk("alias_target", o_tgt, 32'h300);

    cycle(0, 1, 32'h80, 1, 32'h80, 1, 32'h180, 0, 0);
    chk("same_cyc_old", o_hit, 0);
    look(32'h80);
    chk("same_cyc_new", o_hit, 1);

    cycle(0, 0, 0, 1, 32'h40, 1, 32'h500, 0, 1);
    look(32'h40);
    chk("flush_40", o_hit, 0);
    look(32'h80);
    chk("flush_80", o_hit, 0);

    for (int i = 0; i < 20; i++) look(32'h1000 + 32'(i * 4));
    chk("stat4_sat", lcnt4, 15);

    for (int n = 0; n < 3000; n++) begin
      a = {16'h0, 6'(($urandom % 4) * 8), 6'($urandom % 8), 2'b00};
      a = a | (32'($urandom % 4) << 8);
      b = {16'h0, 6'($urandom % 4), 6'($urandom % 8), 2'b00};
      cycle(($urandom % 100) == 0, $urandom % 2, a,
            ($urandom % 4) != 0, b, $urandom % 2,
            32'h100 * ($urandom % 4), $urandom % 2,
            ($urandom % 50) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_branch_predictor.md
# id_branch_predictor

Parametrised dynamic branch predictor for the MIPS pipeline, successor to the static next-PC selection in the decode stage. IF looks up the fetch PC each cycle and receives a predicted next PC. ID writes back the resolved outcome and target of every branch/jump, training a direct-mapped table of tagged saturating counters with stored targets. Saturating lookup/mispredict counters are exported for the debug unit.

## Interface
- `PC_SIZE`, 32, PC and target width.
- `BHT_DEPTH`, 64, number of table entries; power of two, ≥ 2.
- `TAG_SIZE`, 8, tag bits per entry; `2 + log2(BHT_DEPTH) + TAG_SIZE ≤ PC_SIZE`.
- `COUNTER_BITS`, 2, saturating counter width, 1..4.
- `STAT_SIZE`, 32, width of statistics counters.
- `i_clk`  in  1  clock; all state updates on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_lookup_valid`  in  1  IF presents a fetch PC.
- `i_lookup_pc`  in  PC_SIZE  fetch PC.
- `o_pred_hit`  out  1  valid entry with matching tag.
- `o_pred_taken`  out  1  prediction is taken.
- `o_pred_target`  out  PC_SIZE  predicted next PC.
- `i_update_valid`  in  1  ID resolved a control-flow instruction this cycle.
- `i_update_pc`  in  PC_SIZE  PC of the resolved instruction.
- `i_update_taken`  in  1  actual outcome.
- `i_update_target`  in  PC_SIZE  actual taken target.
- `i_update_pred_taken`  in  1  prediction IF used for this instruction.
- `i_flush`  in  1  invalidate the whole table.
- `o_lookup_count`  out  STAT_SIZE  valid lookups since reset.
- `o_mispredict_count`  out  STAT_SIZE  mispredicted updates since reset.

## Operation
- Index = `pc[log2(BHT_DEPTH)+1 : 2]`; tag = the next TAG_SIZE bits above the index.
- Entry fields: valid, tag, counter (COUNTER_BITS), target (PC_SIZE). Table held in registers, not RAM.
- Lookup is combinational from current table state.
  - `o_pred_hit` = valid & tag match & `i_lookup_valid`.
  - `o_pred_taken` = `o_pred_hit` & counter MSB.
  - `o_pred_target` = entry target when `o_pred_taken`, else `i_lookup_pc + 4` (modulo 2^PC_SIZE).
  - When `i_lookup_valid` = 0, all three outputs are 0.
- Update, registered, applied when `i_update_valid`:
  - Hit and taken: counter saturating-increments, target ← `i_update_target`.
  - Hit and not taken: counter saturating-decrements; target unchanged.
  - Miss and taken: allocate/replace the entry. Set valid = 1, tag from PC, counter = weak-taken (`2^(COUNTER_BITS-1)`), target ← `i_update_target`.
  - Miss and not taken: no table change.
- Mispredict condition: `i_update_pred_taken != i_update_taken`, or both taken and the stored target differs from `i_update_target`. On mispredict, `o_mispredict_count` increments.
- Statistics: `o_lookup_count` increments on each `i_lookup_valid`. Both statistics counters saturate at all-ones and never wrap.
- `i_flush`: clears every valid bit next edge; counters, targets and statistics are kept.
- Flush and update in the same cycle: flush wins, the update is discarded, but its mispredict is still counted.
- Priority: reset > flush > update.

## Timing
- Lookup latency 0 cycles (same-cycle combinational).
- Update visible to lookups from the cycle after the update edge.
- Same-index lookup and update in one cycle: the lookup sees the old entry; no bypass.
- Reset (one cycle suffices, any time including mid-update):
  - All valid bits cleared.
  - All counters set to weak-not-taken (`2^(COUNTER_BITS-1) - 1`).
  - Targets cleared to 0; both statistics counters cleared to 0.
  - `o_pred_hit` = 0, `o_pred_taken` = 0; `o_pred_target` = `i_lookup_pc + 4` if `i_lookup_valid`, else 0.
  - Any update in the reset cycle is ignored.
- COUNTER_BITS = 1: counter is a single last-outcome bit; weak-taken = 1, weak-not-taken = 0.

## Test plan
- Reset, then lookup 0x0000_0040 with valid → hit = 0, taken = 0, target = 0x0000_0044; `o_lookup_count` = 1.
- Update pc 0x40 taken target 0x100, pred_taken = 0, then lookup 0x40 next cycle → hit = 1, taken = 1, target = 0x100; `o_mispredict_count` = 1.
- Two not-taken updates on 0x40 (COUNTER_BITS = 2) → counter 2→1→0, lookup taken = 0, target 0x44. A third not-taken update keeps counter at 0.
- Alias: train 0x40 taken, then lookup 0x40 + 4·BHT_DEPTH (same index, different tag) → hit = 0. A taken update at the alias replaces the entry, and the original 0x40 then misses.
- Same-cycle lookup + update at 0x80 (first taken update) → lookup shows hit = 0 that cycle, hit = 1 the next cycle.
- `i_flush` together with an update of 0x40, plus a separate scenario with STAT_SIZE = 4 and 20 lookups:
  - Flush case: all entries miss next cycle, the update is not installed, its mispredict is still counted.
  - STAT_SIZE = 4 case: `o_lookup_count` = 15 (saturated, no wrap).
